// File: rtl/vop2_pkg.sv
// VOP2 issue controller shared definitions: opcodes, instruction field
// layout, FSM state type and opcode legality check (VOP2_DOT2C_EN enables DOT2C).
package vop2_pkg;

    localparam int INST_W   = 32;
    localparam int SRC0_VG  = 8;
    localparam int OP_LSB   = 25;
    localparam int OP_MSB   = 30;
    localparam int RSV_BIT  = 31;

    localparam logic [5:0] OP_DOT2C      = 6'd2;
    localparam logic [5:0] OP_ADD_F32    = 6'd3;
    localparam logic [5:0] OP_SUB_F32    = 6'd4;
    localparam logic [5:0] OP_SUBREV_F32 = 6'd5;
    localparam logic [5:0] OP_MUL_LEG    = 6'd7;
    localparam logic [5:0] OP_MUL_F32    = 6'd8;
    localparam logic [5:0] OP_MUL_I24    = 6'd9;
    localparam logic [5:0] OP_MUL_HI_I24 = 6'd10;

    // Field order matches inst[30:0], so a plain cast decodes it.
    typedef struct packed {
        logic [5:0] op;
        logic [7:0] vdst;
        logic [7:0] vsrc1;
        logic [8:0] src0;
    } vop2_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_S0,
        ST_RD_S1,
        ST_CAP,
        ST_ISSUE,
        ST_WAIT_RES,
        ST_WB
`ifdef VOP2_DOT2C_EN
        , ST_RD_D
`endif
    } state_t;

    function automatic vop2_fields_t decode(input logic [INST_W-1:0] ins);
        return vop2_fields_t'(ins[30:0]);
    endfunction

    function automatic logic is_legal(input logic [INST_W-1:0] ins);
        logic [5:0] op;
        op = ins[OP_MSB:OP_LSB];
        if (ins[RSV_BIT]) begin
            return 1'b0;
        end
        case (op)
            OP_ADD_F32,
            OP_SUB_F32,
            OP_SUBREV_F32,
            OP_MUL_LEG,
            OP_MUL_F32,
            OP_MUL_I24,
            OP_MUL_HI_I24: return 1'b1;
`ifdef VOP2_DOT2C_EN
            OP_DOT2C:      return 1'b1;
`endif
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vop2_issue_ctrl.sv
// VOP2 issue controller: decode, operand fetch, ALU issue, result writeback.
// Ports: inst_* intake, sgpr_* scalar read, vgpr_rd_*/vgpr_wr_* VGPR file,
// alu_* ALU handshake/result, busy, illegal_op. Macro VOP2_DOT2C_EN adds
// the DOT2C accumulator read (RD_D) and drives alu_src2.
import vop2_pkg::*;

module vop2_issue_ctrl #(
    parameter int DATA_W  = 32,
    parameter int VADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inst_valid,
    output logic               inst_ready,
    input  logic [31:0]        inst,
    output logic [7:0]         sgpr_addr,
    input  logic [DATA_W-1:0]  sgpr_data,
    output logic               vgpr_rd_en,
    output logic [VADDR_W-1:0] vgpr_rd_addr,
    input  logic [DATA_W-1:0]  vgpr_rd_data,
    output logic               alu_valid,
    input  logic               alu_ready,
    output logic [5:0]         alu_op,
    output logic [DATA_W-1:0]  alu_src0,
    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    input  logic               alu_res_valid,
    input  logic [DATA_W-1:0]  alu_res_data,
    output logic               vgpr_wr_en,
    output logic [VADDR_W-1:0] vgpr_wr_addr,
    output logic [DATA_W-1:0]  vgpr_wr_data,
    output logic               busy,
    output logic               illegal_op
);

    state_t       state_q;
    state_t       state_d;
    vop2_fields_t f_q;
    logic [DATA_W-1:0] opa_q;
    logic [DATA_W-1:0] opb_q;
    logic [DATA_W-1:0] res_q;
    logic         illegal_q;
    logic         accept;
    logic         legal;
    logic         src0_vgpr;

    assign accept    = (state_q == ST_IDLE) && inst_valid;
    assign legal     = is_legal(inst);
    assign src0_vgpr = f_q.src0[SRC0_VG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        inst_ready   = 1'b0;
        sgpr_addr    = '0;
        vgpr_rd_en   = 1'b0;
        vgpr_rd_addr = '0;
        alu_valid    = 1'b0;
        vgpr_wr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid && legal) begin
                    state_d = ST_RD_S0;
                end
            end
            ST_RD_S0: begin
                if (src0_vgpr) begin
                    vgpr_rd_en   = 1'b1;
                    vgpr_rd_addr = VADDR_W'(f_q.src0[7:0]);
                end else begin
                    sgpr_addr = f_q.src0[7:0];
                end
                state_d = ST_RD_S1;
            end
            ST_RD_S1: begin
                vgpr_rd_en   = 1'b1;
                vgpr_rd_addr = VADDR_W'(f_q.vsrc1);
`ifdef VOP2_DOT2C_EN
                if (f_q.op == OP_DOT2C) begin
                    state_d = ST_RD_D;
                end else begin
                    state_d = ST_CAP;
                end
`else
                state_d = ST_CAP;
`endif
            end
`ifdef VOP2_DOT2C_EN
            ST_RD_D: begin
                vgpr_rd_en   = 1'b1;
                vgpr_rd_addr = VADDR_W'(f_q.vdst);
                state_d      = ST_CAP;
            end
`endif
            ST_CAP: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                alu_valid = 1'b1;
                if (alu_ready) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (alu_res_valid) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                vgpr_wr_en = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef VOP2_DOT2C_EN
    logic [DATA_W-1:0] opc_q;
    logic              is_dot;

    assign is_dot = (f_q.op == OP_DOT2C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q <= '0;
        end else if (accept && legal) begin
            opc_q <= '0;
        end else if (state_q == ST_CAP && is_dot) begin
            opc_q <= vgpr_rd_data;
        end
    end

    assign alu_src2 = opc_q;
`else
    assign alu_src2 = '0;
`endif

    // Operand capture follows the one-cycle VGPR read latency: each state
    // captures the data returned for the read issued by the previous state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q       <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && !legal;
            if (accept && legal) begin
                f_q <= decode(inst);
            end
            unique case (state_q)
                ST_RD_S0: begin
                    if (!src0_vgpr) begin
                        opa_q <= sgpr_data;
                    end
                end
                ST_RD_S1: begin
                    if (src0_vgpr) begin
                        opa_q <= vgpr_rd_data;
                    end
                end
`ifdef VOP2_DOT2C_EN
                ST_RD_D: begin
                    opb_q <= vgpr_rd_data;
                end
                ST_CAP: begin
                    if (!is_dot) begin
                        opb_q <= vgpr_rd_data;
                    end
                end
`else
                ST_CAP: begin
                    opb_q <= vgpr_rd_data;
                end
`endif
                ST_WAIT_RES: begin
                    if (alu_res_valid) begin
                        res_q <= alu_res_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_op       = f_q.op;
    assign alu_src0     = opa_q;
    assign alu_src1     = opb_q;
    assign vgpr_wr_addr = VADDR_W'(f_q.vdst);
    assign vgpr_wr_data = res_q;
    assign busy         = (state_q != ST_IDLE);
    assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_vop2_issue_ctrl.sv
// Scoreboard bench for vop2_issue_ctrl: VGPR/SGPR models, ALU model that
// checks issued operands, monitor that checks writes and illegal pulses.
module tb_vop2_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [7:0]  sgpr_addr;
    logic [31:0] sgpr_data;
    logic        vgpr_rd_en;
    logic [7:0]  vgpr_rd_addr;
    logic [31:0] vgpr_rd_data;
    logic        alu_valid;
    logic        alu_ready;
    logic [5:0]  alu_op;
    logic [31:0] alu_src0;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic        alu_res_valid;
    logic [31:0] alu_res_data;
    logic        vgpr_wr_en;
    logic [7:0]  vgpr_wr_addr;
    logic [31:0] vgpr_wr_data;
    logic        busy;
    logic        illegal_op;

    vop2_issue_ctrl #(.DATA_W(32), .VADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .sgpr_addr(sgpr_addr), .sgpr_data(sgpr_data),
        .vgpr_rd_en(vgpr_rd_en), .vgpr_rd_addr(vgpr_rd_addr),
        .vgpr_rd_data(vgpr_rd_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_src0(alu_src0), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_res_valid(alu_res_valid), .alu_res_data(alu_res_data),
        .vgpr_wr_en(vgpr_wr_en), .vgpr_wr_addr(vgpr_wr_addr),
        .vgpr_wr_data(vgpr_wr_data),
        .busy(busy), .illegal_op(illegal_op)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
    } alu_exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_exp_t;

    alu_exp_t   exp_alu[$];
    wr_exp_t    exp_wr[$];
    int         exp_ill[$];
    logic [7:0] rd_log[$];
    logic [31:0] vgpr [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int stall_cfg = 0;
    int lat_cfg   = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (vgpr_rd_en) vgpr_rd_data <= vgpr[vgpr_rd_addr];
    end

    assign sgpr_data = (sgpr_addr == 8'h12) ? 32'h4040_0000
                                            : {24'hDEAD00, sgpr_addr};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic r, input logic [5:0] op,
                                       input logic [7:0] vd,
                                       input logic [7:0] v1,
                                       input logic [8:0] s0);
        return {r, op, vd, v1, s0};
    endfunction

    // ALU model: compares presented operands every ISSUE cycle (so stalls
    // also check stability), returns src0+src1+src2 after lat_cfg cycles.
    initial begin
        int       cnt;
        bit       seen;
        int       pend;
        logic [31:0] pdata;
        alu_exp_t e;
        alu_ready = 0; alu_res_valid = 0; alu_res_data = 0;
        cnt = 0; seen = 0; pend = 0; pdata = 0;
        forever begin
            @(negedge clk);
            alu_res_valid = 0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    alu_res_valid = 1;
                    alu_res_data  = pdata;
                end
            end
            if (alu_valid) begin
                if (!seen) begin
                    seen = 1;
                    cnt  = stall_cfg;
                end
                if (exp_alu.size() == 0) begin
                    chk("alu_unexpected_issue", 1, 0);
                    alu_ready = 1;
                    seen = 0;
                end else begin
                    e = exp_alu[0];
                    chk("alu_op", alu_op, e.op);
                    chk("alu_src0", alu_src0, e.s0);
                    chk("alu_src1", alu_src1, e.s1);
                    chk("alu_src2", alu_src2, e.s2);
                    if (cnt > 0) begin
                        cnt--;
                        alu_ready = 0;
                    end else begin
                        alu_ready = 1;
                        pend  = lat_cfg;
                        pdata = alu_src0 + alu_src1 + alu_src2;
                        void'(exp_alu.pop_front());
                        seen = 0;
                    end
                end
            end else begin
                alu_ready = 0;
            end
        end
    end

    // Monitor: writebacks and illegal pulses against the scoreboard.
    initial begin
        wr_exp_t w;
        int      c;
        forever begin
            @(negedge clk);
            if (vgpr_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", vgpr_wr_addr, w.addr);
                    chk("wr_data", vgpr_wr_data, w.data);
                    chk("wr_cycle", cyc, w.cyc);
                end
            end
            if (illegal_op) begin
                if (exp_ill.size() == 0) begin
                    chk("ill_unexpected", 1, 0);
                end else begin
                    c = exp_ill.pop_front();
                    chk("ill_cycle", cyc, c);
                end
            end
            if (vgpr_rd_en) rd_log.push_back(vgpr_rd_addr);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_inst_ready"}, inst_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_strobes"},
            {alu_valid, vgpr_rd_en, vgpr_wr_en, illegal_op}, 0);
        chk({tag, "_addrs"}, {sgpr_addr, vgpr_rd_addr, vgpr_wr_addr}, 0);
        chk({tag, "_alu_op"}, alu_op, 0);
        chk({tag, "_src01"}, {alu_src0, alu_src1}, 0);
        chk({tag, "_src2_wdata"}, {alu_src2, vgpr_wr_data}, 0);
    endtask

    // Offer an instruction; expectations are queued at the accept point so
    // the monitor never races them.
    task automatic send(input logic [31:0] ins, input bit ill,
                        input bit has_wr, input logic [7:0] waddr,
                        input logic [31:0] wdata, input int lat,
                        output int acc);
        int      n;
        wr_exp_t w;
        n = 0;
        inst = ins;
        inst_valid = 1;
        while (!inst_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        acc = cyc;
        if (ill) exp_ill.push_back(acc + 1);
        if (has_wr) begin
            w.addr = waddr;
            w.data = wdata;
            w.cyc  = acc + lat;
            exp_wr.push_back(w);
        end
        @(negedge clk);
        inst_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || exp_wr.size() != 0 || exp_alu.size() != 0)
               && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle_timeout"}, (n >= 100), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic alu_exp_t ae(input logic [5:0] op,
                                    input logic [31:0] a,
                                    input logic [31:0] b,
                                    input logic [31:0] c);
        alu_exp_t e;
        e.op = op; e.s0 = a; e.s1 = b; e.s2 = c;
        return e;
    endfunction

    initial begin
        int a1;
        int a2;
        for (int i = 0; i < 256; i++) vgpr[i] = {24'hA5A5A5, i[7:0]};
        vgpr[5] = 32'h3F80_0000;
        vgpr[7] = 32'h4000_0000;
        vgpr[4] = 32'h0000_0011;
        rst_n = 0;
        inst_valid = 0;
        inst = 0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1;
        @(negedge clk);

        // 1 + 2: ADD from VGPRs, then MUL with SGPR src0, back-to-back
        rd_log.delete();
        exp_alu.push_back(ae(6'd3, 32'h3F80_0000, 32'h4000_0000, 0));
        exp_alu.push_back(ae(6'd8, 32'h4040_0000, 32'h4000_0000, 0));
        send(mk(0, 6'd3, 8'd9, 8'd7, 9'h105), 0, 1,
             8'd9, 32'h7F80_0000, 6, a1);
        send(mk(0, 6'd8, 8'd10, 8'd7, 9'h012), 0, 1,
             8'd10, 32'h8040_0000, 6, a2);
        chk("t2_sgpr_addr", sgpr_addr, 8'h12);
        chk("t2_no_rd_s0", vgpr_rd_en, 0);
        chk("t12_next_accept", a2 - a1, 7);
        wait_idle("t12");
        chk("t12_rd_count", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            chk("t12_rd0", rd_log[0], 8'd5);
            chk("t12_rd1", rd_log[1], 8'd7);
            chk("t12_rd2", rd_log[2], 8'd7);
        end

        // 3: ALU stalls five cycles in ISSUE
        stall_cfg = 5;
        exp_alu.push_back(ae(6'd3, 32'h3F80_0000, 32'h4000_0000, 0));
        send(mk(0, 6'd3, 8'd11, 8'd7, 9'h105), 0, 1,
             8'd11, 32'h7F80_0000, 11, a1);
        wait_idle("t3");
        stall_cfg = 0;

        // 4: unsupported opcode and reserved bit set
        rd_log.delete();
        send(mk(0, 6'h3F, 8'd9, 8'd7, 9'h105), 1, 0, 0, 0, 0, a1);
        chk("t4_ready_after_ill", {inst_ready, busy}, 2'b10);
        send(mk(1, 6'd3, 8'd9, 8'd7, 9'h105), 1, 0, 0, 0, 0, a1);
        chk("t4_ready_after_rsv", {inst_ready, busy}, 2'b10);
        wait_idle("t4");
        chk("t4_no_reads", rd_log.size(), 0);

        // 5: DOT2C reads vdst as the accumulator operand
        rd_log.delete();
`ifdef VOP2_DOT2C_EN
        exp_alu.push_back(ae(6'd2, 32'h3F80_0000, 32'h4000_0000,
                             32'h0000_0011));
        send(mk(0, 6'd2, 8'd4, 8'd7, 9'h105), 0, 1,
             8'd4, 32'h7F80_0011, 7, a1);
        wait_idle("t5");
        chk("t5_rd_count", rd_log.size(), 3);
        if (rd_log.size() == 3) chk("t5_rd_d", rd_log[2], 8'd4);
`else
        send(mk(0, 6'd2, 8'd4, 8'd7, 9'h105), 1, 0, 0, 0, 0, a1);
        wait_idle("t5");
        chk("t5_no_reads", rd_log.size(), 0);
`endif

        // 6: reset while waiting for the result, strobe arrives afterwards
        lat_cfg = 4;
        exp_alu.push_back(ae(6'd3, 32'h3F80_0000, 32'h4000_0000, 0));
        send(mk(0, 6'd3, 8'd12, 8'd7, 9'h105), 0, 0, 0, 0, 0, a1);
        repeat (5) @(negedge clk);
        chk("t6_in_wait", {busy, alu_valid}, 2'b10);
        rst_n = 0;
        #1;
        chk_reset("t6_rst");
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        lat_cfg = 1;
        chk("t6_idle_after", {inst_ready, busy}, 2'b10);
        wait_idle("t6");

        chk("end_wr_queue", exp_wr.size(), 0);
        chk("end_ill_queue", exp_ill.size(), 0);
        chk("end_alu_queue", exp_alu.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
